// File: rtl/dot_product_datapath_pkg.sv
// Shared definitions for the dot-product compute stage: default sizes, derived
// widths, pipeline depth and the FSM state encoding.
package dot_product_datapath_pkg;

  localparam int DATA_WIDTH        = 8;
  localparam int ADDR_WIDTH        = 4;
  localparam int NUMS_DATA_IN_BITS = 4;

  // Rd_Valid -> Prod_Wr_En latency; MEMController sizes its Pipeline_Tail from this.
  localparam int PIPE_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dp_state_e;

  function automatic int prod_width(input int data_width);
    return 2 * data_width;
  endfunction

  function automatic int acc_width(input int data_width, input int nums_data_in_bits);
    return prod_width(data_width) + nums_data_in_bits;
  endfunction

endpackage

// File: rtl/dot_product_datapath_if.sv
// Bus between MEMController/SRAM side and the dot-product datapath: read-side
// inputs in, product write port and dot-product status out.
interface dot_product_datapath_if #(
  parameter int Data_Width        = dot_product_datapath_pkg::DATA_WIDTH,
  parameter int Addr_Width        = dot_product_datapath_pkg::ADDR_WIDTH,
  parameter int Nums_Data_in_bits = dot_product_datapath_pkg::NUMS_DATA_IN_BITS
);

  localparam int Prod_Width = dot_product_datapath_pkg::prod_width(Data_Width);
  localparam int Acc_Width  = dot_product_datapath_pkg::acc_width(Data_Width, Nums_Data_in_bits);

  logic                         start;
  logic                         Rd_Valid;
  logic [Addr_Width-1:0]        Rd_Addr;
  logic [Data_Width-1:0]        Data_A;
  logic [Data_Width-1:0]        Data_B;
  logic                         Prod_Wr_En;
  logic [Addr_Width-1:0]        Prod_Wr_Addr;
  logic [Prod_Width-1:0]        Prod_Data;
  logic [Acc_Width-1:0]         Dot_Sum;
  logic                         Dot_Valid;
  logic                         busy;
  logic [Nums_Data_in_bits:0]   elem_count;

  modport master (
    output start, Rd_Valid, Rd_Addr, Data_A, Data_B,
    input  Prod_Wr_En, Prod_Wr_Addr, Prod_Data, Dot_Sum, Dot_Valid, busy, elem_count
  );

  modport slave (
    input  start, Rd_Valid, Rd_Addr, Data_A, Data_B,
    output Prod_Wr_En, Prod_Wr_Addr, Prod_Data, Dot_Sum, Dot_Valid, busy, elem_count
  );

endinterface

// File: rtl/dp_mul_stage.sv
// S1 -> S2 pipeline stage: multiplies the captured SRAM words and registers the
// product with its valid bit and address. Kept separate so the multiplier can be swapped.
module dp_mul_stage
  import dot_product_datapath_pkg::*;
#(
  parameter  int Data_Width = DATA_WIDTH,
  parameter  int Addr_Width = ADDR_WIDTH,
  localparam int Prod_Width = prod_width(Data_Width)
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  valid_i,
  input  logic [Addr_Width-1:0] addr_i,
  input  logic [Data_Width-1:0] a_i,
  input  logic [Data_Width-1:0] b_i,
  output logic                  valid_o,
  output logic [Addr_Width-1:0] addr_o,
  output logic [Prod_Width-1:0] prod_o
);

  logic                  valid_q;
  logic [Addr_Width-1:0] addr_q;
  logic [Prod_Width-1:0] prod_d, prod_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    prod_d = '0;
    if (valid_i) begin
      prod_d = Prod_Width'(a_i) * Prod_Width'(b_i);
    end
  end

  // NOTE: state is updated with <= only, so all registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      // NOTE: data registers are reset too, so the product bus reads 0 straight out of reset.
      valid_q <= 1'b0;
      addr_q  <= '0;
      prod_q  <= '0;
    end else begin
      valid_q <= valid_i;
      addr_q  <= addr_i;
      prod_q  <= prod_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign prod_o  = prod_q;

endmodule

// File: rtl/dot_product_datapath.sv
// Dot-product compute stage: 4-stage multiply pipeline fed by the input SRAM reads,
// per-element product writes to the output SRAM, and an accumulated sum with done pulse.
module dot_product_datapath
  import dot_product_datapath_pkg::*;
#(
  parameter int Data_Width        = DATA_WIDTH,
  parameter int Addr_Width        = ADDR_WIDTH,
  parameter int Nums_Data_in_bits = NUMS_DATA_IN_BITS
) (
  input logic                   clk,
  input logic                   Comp_reset,
  dot_product_datapath_if.slave bus
);

  localparam int Prod_Width = prod_width(Data_Width);
  localparam int Acc_Width  = acc_width(Data_Width, Nums_Data_in_bits);
  localparam int Cnt_Width  = Nums_Data_in_bits + 1;
  localparam logic [Cnt_Width-1:0] Nums_Data = Cnt_Width'(1 << Nums_Data_in_bits);

  dp_state_e             state_q, state_d;
  logic [Cnt_Width-1:0]  count_q, count_d;
  logic [Acc_Width-1:0]  acc_q, acc_d;
  logic                  accept;
  logic                  clear_acc;
  logic                  pipe_empty;

  logic                  s0_valid_q, s0_valid_d;
  logic [Addr_Width-1:0] s0_addr_q, s0_addr_d;
  logic                  s1_valid_q;
  logic [Addr_Width-1:0] s1_addr_q;
  logic [Data_Width-1:0] s1_a_q, s1_b_q;
  logic                  s2_valid;
  logic [Addr_Width-1:0] s2_addr;
  logic [Prod_Width-1:0] s2_prod;
  logic                  s3_valid_q;
  logic [Addr_Width-1:0] s3_addr_q, s3_addr_d;
  logic [Prod_Width-1:0] s3_prod_q, s3_prod_d;

  assign pipe_empty = !(s0_valid_q || s1_valid_q || s2_valid || s3_valid_q);

  // Only RUN admits elements; once Nums_Data are in, further strobes never enter S0.
  always_comb begin : fsm_next
    state_d   = state_q;
    count_d   = count_q;
    accept    = 1'b0;
    clear_acc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          count_d   = '0;
          clear_acc = 1'b1;
        end
      end
      RUN: begin
        if (bus.Rd_Valid) begin
          accept  = 1'b1;
          count_d = count_q + 1'b1;
          if (count_d == Nums_Data) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : pipe_next
    s0_valid_d = accept;
    s0_addr_d  = accept ? bus.Rd_Addr : '0;
    s3_addr_d  = s2_valid ? s2_addr : '0;
    s3_prod_d  = s2_valid ? s2_prod : '0;
    acc_d      = acc_q;
    if (clear_acc) begin
      acc_d = '0;
    end else if (s2_valid) begin
      acc_d = acc_q + Acc_Width'(s2_prod);
    end
  end

  always_ff @(posedge clk) begin
    if (Comp_reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      s0_valid_q <= 1'b0;
      s0_addr_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s3_valid_q <= 1'b0;
      s3_addr_q  <= '0;
      s3_prod_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      s0_valid_q <= s0_valid_d;
      s0_addr_q  <= s0_addr_d;
      s1_valid_q <= s0_valid_q;
      s1_addr_q  <= s0_addr_q;
      s1_a_q     <= bus.Data_A;
      s1_b_q     <= bus.Data_B;
      s3_valid_q <= s2_valid;
      s3_addr_q  <= s3_addr_d;
      s3_prod_q  <= s3_prod_d;
    end
  end

  dp_mul_stage #(
    .Data_Width (Data_Width),
    .Addr_Width (Addr_Width)
  ) u_mul (
    .clk     (clk),
    .reset_i (Comp_reset),
    .valid_i (s1_valid_q),
    .addr_i  (s1_addr_q),
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .valid_o (s2_valid),
    .addr_o  (s2_addr),
    .prod_o  (s2_prod)
  );

  assign bus.Prod_Wr_En   = s3_valid_q;
  assign bus.Prod_Wr_Addr = s3_addr_q;
  assign bus.Prod_Data    = s3_prod_q;
  assign bus.Dot_Sum      = acc_q;
  assign bus.Dot_Valid    = (state_q == DONE);
  assign bus.busy         = (state_q == RUN) || (state_q == DRAIN);
  assign bus.elem_count   = count_q;

endmodule

// File: tb/tb_dot_product_datapath.sv
// Randomized bench for dot_product_datapath: an SRAM model feeds read data one cycle
// after each strobe, and a transaction-level model predicts every output each cycle.
module tb_dot_product_datapath;
  import dot_product_datapath_pkg::*;

  localparam int DW    = DATA_WIDTH;
  localparam int AW    = ADDR_WIDTH;
  localparam int NB    = NUMS_DATA_IN_BITS;
  localparam int N     = 1 << NB;
  localparam int DEPTH = 1 << AW;
  localparam int BIG   = 1 << 30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dot_product_datapath_if bus ();

  dot_product_datapath dut (
    .clk        (clk),
    .Comp_reset (rst),
    .bus        (bus)
  );

  typedef struct {
    int     cyc;
    int     addr;
    longint prod;
  } wr_t;

  wr_t    exp_q[$];
  int     mem_a[DEPTH];
  int     mem_b[DEPTH];
  int     cyc;
  int     n_checks;
  int     n_pass;
  int     m_state;      // 0 idle, 1 accepting, 2 finishing
  int     v_cnt;
  longint v_sum;
  int     done_cyc;
  int     busy_lo;
  int     dv_seen;
  logic   prev_rv;
  int     prev_addr;
  longint exp_sum;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
  endtask

  // One clock: check outputs against the model, then drive this cycle's inputs.
  task automatic cycle(input logic st, input logic rv, input int addr, input logic rs);
    wr_t    w;
    logic   exp_we;
    int     exp_addr;
    longint exp_prod;
    @(posedge clk);
    #1;
    cyc++;
    exp_we = 1'b0;
    exp_addr = 0;
    exp_prod = 0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      w = exp_q.pop_front();
      exp_we = 1'b1;
      exp_addr = w.addr;
      exp_prod = w.prod;
      v_sum += w.prod;
    end
    check("prod_wr_en", bus.Prod_Wr_En, exp_we);
    check("prod_wr_addr", bus.Prod_Wr_Addr, exp_addr);
    check("prod_data", bus.Prod_Data, exp_prod);
    check("dot_sum", bus.Dot_Sum, v_sum);
    check("elem_count", bus.elem_count, v_cnt);
    check("dot_valid", bus.Dot_Valid, cyc == done_cyc);
    check("busy", bus.busy, (cyc >= busy_lo) && (cyc < done_cyc));
    if (bus.Dot_Valid === 1'b1) dv_seen++;

    rst          = rs;
    bus.start    = st;
    bus.Rd_Valid = rv;
    bus.Rd_Addr  = AW'(addr);
    bus.Data_A   = prev_rv ? DW'(mem_a[prev_addr]) : DW'($urandom);
    bus.Data_B   = prev_rv ? DW'(mem_b[prev_addr]) : DW'($urandom);
    prev_rv      = rv;
    prev_addr    = addr;

    if (rs) begin
      exp_q.delete();
      v_cnt    = 0;
      v_sum    = 0;
      m_state  = 0;
      done_cyc = BIG;
      busy_lo  = BIG;
    end else begin
      if (m_state == 2 && cyc > done_cyc) m_state = 0;
      if (m_state == 0) begin
        if (st) begin
          m_state  = 1;
          v_cnt    = 0;
          v_sum    = 0;
          busy_lo  = cyc + 1;
          done_cyc = BIG;
        end
      end else if (m_state == 1 && rv) begin
        w.cyc  = cyc + PIPE_DEPTH;
        w.addr = addr;
        w.prod = longint'(mem_a[addr]) * longint'(mem_b[addr]);
        exp_q.push_back(w);
        v_cnt++;
        if (v_cnt == N) begin
          m_state  = 2;
          // last S3 write at +4, pipeline seen empty at +5, done pulse at +6
          done_cyc = cyc + PIPE_DEPTH + 2;
        end
      end
    end
  endtask

  task automatic run(input int n_pulses, input int gap_min, input int gap_span,
                     input bit addr_rand, input int abort_after);
    int sent;
    int a;
    sent = 0;
    dv_seen = 0;
    cycle(1'b1, 1'b1, 5, 1'b0);
    while (sent < n_pulses) begin
      if (sent == abort_after) begin
        cycle(1'b0, 1'b0, 0, 1'b1);
        return;
      end
      a = addr_rand ? int'($urandom_range(0, DEPTH - 1)) : (sent % DEPTH);
      cycle(sent == 3, 1'b1, a, 1'b0);
      sent++;
      repeat (gap_min + int'($urandom_range(0, gap_span))) cycle(1'b0, 1'b0, 0, 1'b0);
    end
    repeat (10) cycle(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), 1'b0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = int'($urandom_range(0, (1 << DW) - 1));
      mem_b[i] = int'($urandom_range(0, (1 << DW) - 1));
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    m_state  = 0;
    v_cnt    = 0;
    v_sum    = 0;
    done_cyc = BIG;
    busy_lo  = BIG;
    dv_seen  = 0;
    prev_rv  = 1'b0;
    prev_addr = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.Rd_Valid = 1'b0;
    bus.Rd_Addr  = '0;
    bus.Data_A   = '0;
    bus.Data_B   = '0;
    repeat (2) @(posedge clk);
    cycle(1'b0, 1'b0, 0, 1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = i;
      mem_b[i] = 1;
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, i, 1'b0);

    run(16, 0, 0, 1'b0, -1);
    check("t1_sum", bus.Dot_Sum, 120);
    check("t1_done_pulses", dv_seen, 1);

    run(16, 1, 0, 1'b0, -1);
    check("t3_gap_sum", bus.Dot_Sum, 120);
    check("t3_done_pulses", dv_seen, 1);

    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 255;
      mem_b[i] = 255;
    end
    run(16, 0, 0, 1'b0, -1);
    check("t2_max_sum", bus.Dot_Sum, 1040400);
    check("t2_done_pulses", dv_seen, 1);

    fill_random();
    exp_sum = 0;
    for (int i = 0; i < N; i++) exp_sum += longint'(mem_a[i]) * longint'(mem_b[i]);
    run(20, 0, 0, 1'b0, -1);
    check("t4_sum", bus.Dot_Sum, exp_sum);
    check("t4_elem_count", bus.elem_count, N);
    check("t4_done_pulses", dv_seen, 1);

    run(20, 0, 0, 1'b0, 7);
    cycle(1'b0, 1'b0, 0, 1'b0);
    check("t5_abort_sum", bus.Dot_Sum, 0);
    check("t5_abort_count", bus.elem_count, 0);
    check("t5_abort_pulses", dv_seen, 0);
    run(16, 0, 0, 1'b0, -1);
    check("t5_fresh_sum", bus.Dot_Sum, exp_sum);
    check("t5_done_pulses", dv_seen, 1);

    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, int'($urandom_range(0, DEPTH - 1)), 1'b0);
    check("t6_sum_held", bus.Dot_Sum, exp_sum);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      run(16 + int'($urandom_range(0, 4)), 0, 2, 1'b1, -1);
      check("rand_sum", bus.Dot_Sum, v_sum);
      check("rand_done_pulses", dv_seen, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
